// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding a 16x-oversampling UART transmitter.
//               CPU writes are buffered in a register array. The head byte is
//               presented on tx_data_o/tx_valid_o. The FIFO advances only when
//               the transmitter's ready falls while valid is high, which marks
//               the capture of the byte. The block also provides registered
//               level/full/empty status, a low-water interrupt, a sticky
//               overflow flag and a synchronous flush.
// Optional    : define UART_TX_FIFO_STATS_EN to add tx_count_o, a 32-bit
//               count of transmitted (popped) bytes.
// Ports       : clk, rst (async, active-low)
//               wr_en_i/wr_data_i   bus write of one byte
//               flush_i             synchronous clear of contents
//               tx_data_o/tx_valid_o/tx_ready_i  transmitter handshake
//               full_o/empty_o/level_o/irq_low_o  registered status
//               ovf_o/ovf_clr_i     sticky overflow flag and its clear
//               tx_count_o          (optional) popped-byte counter
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int LOW_WM = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en_i,
   input  logic [7:0]    wr_data_i,
   input  logic          flush_i,
   output logic [7:0]    tx_data_o,
   output logic          tx_valid_o,
   input  logic          tx_ready_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o,
   output logic          irq_low_o,
   output logic          ovf_o,
   input  logic          ovf_clr_i
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [31:0]   tx_count_o
`endif
);

   localparam logic [AW:0] c_DEPTH  = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_LOW_WM = (AW+1)'(LOW_WM);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic          r_ready_q;

   logic          w_pop;
   logic          w_push;
   logic          w_ovf_set;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [AW-1:0] w_wr_ptr_nxt;
   logic [AW:0]   w_count_nxt;
   logic [7:0]    w_data_nxt;

   always_comb begin
      // The transmitter drops ready on the tick where it latches data, so a
      // falling edge while valid is the capture event.
      w_pop     = tx_valid_o & r_ready_q & ~tx_ready_i;
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      w_push    = wr_en_i & (~full_o | w_pop);
      w_ovf_set = wr_en_i & full_o & ~w_pop;

      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      if (flush_i) begin
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_push) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
         if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
         endcase
      end

      // Look ahead to the next head so tx_data_o is correct in the same cycle
      // tx_valid_o rises. If the byte being written lands in the next head
      // slot it is forwarded, since the array does not hold it yet.
      if (w_count_nxt == '0) begin
         w_data_nxt = 8'h00;
      end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_data_nxt = wr_data_i;
      end else begin
         w_data_nxt = r_mem[w_rd_ptr_nxt];
      end
   end

   // Storage array carries no reset; its contents are only observed through
   // the registered head, which is qualified by the count.
   always_ff @(posedge clk) begin
      if (w_push && !flush_i) begin
         r_mem[r_wr_ptr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_ready_q  <= 1'b1;
         tx_data_o  <= 8'h00;
         tx_valid_o <= 1'b0;
         full_o     <= 1'b0;
         empty_o    <= 1'b1;
         level_o    <= '0;
         irq_low_o  <= 1'b1;
         ovf_o      <= 1'b0;
      end else begin
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_count    <= w_count_nxt;
         r_ready_q  <= tx_ready_i;
         tx_data_o  <= w_data_nxt;
         tx_valid_o <= (w_count_nxt != '0);
         full_o     <= (w_count_nxt == c_DEPTH);
         empty_o    <= (w_count_nxt == '0);
         level_o    <= w_count_nxt;
         irq_low_o  <= (w_count_nxt <= c_LOW_WM);
         // Set has priority over a simultaneous clear.
         if (w_ovf_set) begin
            ovf_o <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
         end
      end
   end

`ifdef UART_TX_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_count_o <= '0;
      end else if (flush_i) begin
         tx_count_o <= '0;
      end else if (w_pop) begin
         tx_count_o <= tx_count_o + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based reference
//               model tracks the contents; a behavioural transmitter drops
//               ready to capture bytes, which are collected and compared
//               against the written byte streams.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int LOW_WM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en_i;
   logic [7:0]    wr_data_i;
   logic          flush_i;
   logic [7:0]    tx_data_o;
   logic          tx_valid_o;
   logic          tx_ready_i;
   logic          full_o;
   logic          empty_o;
   logic [AW:0]   level_o;
   logic          irq_low_o;
   logic          ovf_o;
   logic          ovf_clr_i;
`ifdef UART_TX_FIFO_STATS_EN
   logic [31:0]   tx_count_o;
`endif

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .LOW_WM(LOW_WM)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en_i),
      .wr_data_i  (wr_data_i),
      .flush_i    (flush_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .level_o    (level_o),
      .irq_low_o  (irq_low_o),
      .ovf_o      (ovf_o),
      .ovf_clr_i  (ovf_clr_i)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .tx_count_o (tx_count_o)
`endif
   );

   // Reference model state
   logic [7:0]  q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   logic        m_ovf;
   logic        prev_rdy;
   int unsigned m_stat;

   int n_checks = 0;
   int n_err    = 0;
   int mode;       // 0 random transmitter, 1 ready held high, 2 ready held low
   int hold;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("level", 32'(level_o), 32'(q.size()));
      check("empty", 32'(empty_o), 32'(q.size() == 0));
      check("full",  32'(full_o),  32'(q.size() == DEPTH));
      check("valid", 32'(tx_valid_o), 32'(q.size() != 0));
      check("irq_low", 32'(irq_low_o), 32'(q.size() <= LOW_WM));
      check("ovf", 32'(ovf_o), 32'(m_ovf));
      if (q.size() != 0) check("data", 32'(tx_data_o), 32'(q[0]));
`ifdef UART_TX_FIFO_STATS_EN
      check("tx_count", tx_count_o, m_stat);
`endif
   endtask

   // One clock: drive at negedge, update model at posedge, check at negedge.
   task automatic cycle(input logic wr, input logic [7:0] d, input logic fl, input logic clr);
      logic r;
      logic pop;
      logic push_ok;
      logic ovf_set;
      r = tx_ready_i;
      if (!fl) begin
         case (mode)
            1: r = 1'b1;
            2: r = 1'b0;
            default: begin
               if (r) begin
                  if ($urandom_range(0, 3) == 0) begin
                     r    = 1'b0;
                     hold = $urandom_range(1, 5);
                  end
               end else if (hold > 0) begin
                  hold--;
               end else begin
                  r = 1'b1;
               end
            end
         endcase
      end
      // Transmitter latches the presented byte when it drops ready.
      if (prev_rdy && !r && tx_valid_o) rx_q.push_back(tx_data_o);
      wr_en_i    = wr;
      wr_data_i  = d;
      flush_i    = fl;
      ovf_clr_i  = clr;
      tx_ready_i = r;
      @(posedge clk);
      pop      = (q.size() > 0) && prev_rdy && !r;
      prev_rdy = r;
      push_ok  = wr && ((q.size() < DEPTH) || pop);
      ovf_set  = wr && (q.size() == DEPTH) && !pop;
      if (fl) begin
         q.delete();
         m_stat = 0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            m_stat++;
         end
         if (push_ok) q.push_back(d);
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic drain();
      mode = 0;
      for (int i = 0; i < 1000 && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("drain_timeout", 32'(q.size()), 32'd0);
      // Let the transmitter finish any pending hold so ready returns high.
      mode = 1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic compare_rx(input string tag);
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) check(tag, 32'(rx_q[i]), 32'(exp_q[i]));
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf    = 1'b0;
      prev_rdy = 1'b1;
      m_stat   = 0;
   endtask

   initial begin
      rst = 1'b0; wr_en_i = 1'b0; wr_data_i = 8'h00; flush_i = 1'b0;
      ovf_clr_i = 1'b0; tx_ready_i = 1'b1; mode = 1; hold = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;
      @(negedge clk);
      check_all();

      // Two bytes, ready held high: no capture for 1000 cycles.
      rx_q.delete();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      repeat (1000) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("no_pop_high", 32'(rx_q.size()), 32'd0);
      drain();
      exp_q = '{8'hA5, 8'h3C};
      compare_rx("order2");
      check("level_zero", 32'(level_o), 32'd0);

      // Overfill with ready held low: 17th byte dropped, ovf set then cleared.
      mode = 2;
      rx_q.delete();
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("full_lvl", 32'(level_o), 32'd16);
      check("ovf_set", 32'(ovf_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", 32'(ovf_o), 32'd0);

      // Full FIFO: push and pop on the same edge.
      mode = 1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      mode = 2;
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      check("full_pp_lvl", 32'(level_o), 32'd16);
      check("full_pp_ovf", 32'(ovf_o), 32'd0);
      drain();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
      exp_q.push_back(8'hEE);
      compare_rx("ovf_seq");

      // Pointer wrap: 40 bytes with random write gaps.
      mode = 0;
      rx_q.delete();
      begin
         int k;
         k = 0;
         for (int c = 0; c < 3000 && k < 40; c++) begin
            if (($urandom_range(0, 2) != 0) && (q.size() < DEPTH)) begin
               cycle(1'b1, 8'(k), 1'b0, 1'b0);
               k++;
            end else begin
               cycle(1'b0, 8'h00, 1'b0, 1'b0);
            end
         end
         check("wrap_timeout", 32'(k), 32'd40);
      end
      drain();
      exp_q.delete();
      for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
      compare_rx("wrap");

      // Flush with six queued bytes.
      mode = 1;
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      check("pre_flush_lvl", 32'(level_o), 32'd6);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("flush_lvl", 32'(level_o), 32'd0);
      check("flush_valid", 32'(tx_valid_o), 32'd0);

      // Random traffic including flushes and overflow clears.
      mode = 0;
      for (int c = 0; c < 600; c++) begin
         logic wr, fl, clr;
         wr  = 1'($urandom_range(0, 1));
         fl  = ($urandom_range(0, 40) == 0);
         clr = ($urandom_range(0, 12) == 0);
         if (fl) wr = 1'b0;
         cycle(wr, 8'($urandom), fl, clr);
      end

      // Asynchronous reset in the middle of operation.
      mode = 2;
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      wr_en_i = 1'b0; flush_i = 1'b0; ovf_clr_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b1;
      mode = 1;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
